// File: rtl/clk_en_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_scheduler_if
// Description : Request / clock-enable bundle between the requesting counter
//               slices and the round-robin clock-enable scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_en_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic             hold;
    logic [N_REQ-1:0] ce;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic [N_REQ-1:0] done;
    logic             busy;

    // Requesting side: raises requests and hold, consumes enables and status.
    modport master (
        output req, hold,
        input  ce, gnt_id, gnt_valid, done, busy
    );

    // Scheduler side.
    modport slave (
        input  req, hold,
        output ce, gnt_id, gnt_valid, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/clk_en_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_scheduler
// Description : Round-robin clock-enable scheduler. Grants one counter slice
//               at a time a window of BURST_LEN active clock-enable cycles,
//               followed by a GAP_LEN settling gap. hold masks the enable
//               without losing burst credit; dropping the request aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_scheduler #(
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = 8,
    parameter int GAP_LEN   = 2,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    clk_en_scheduler_if.slave bus
);

    localparam int                 c_id_w      = $clog2(N_REQ);
    localparam logic [N_REQ-1:0]   c_one       = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   c_burst_init = CNT_W'(BURST_LEN - 1);
    localparam bit                 c_has_gap   = (GAP_LEN > 0);
    localparam logic [CNT_W-1:0]   c_gap_init  = c_has_gap ? CNT_W'(GAP_LEN - 1) : '0;
    localparam logic [c_id_w-1:0]  c_last_init = c_id_w'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   ce_q, ce_d;
    logic [c_id_w-1:0]  gnt_id_q, gnt_id_d;
    logic [c_id_w-1:0]  last_q, last_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [N_REQ-1:0]   done_q, done_d;

    logic               w_hi_found;
    logic [c_id_w-1:0]  w_hi_id;
    logic [c_id_w-1:0]  w_lo_id;
    logic [c_id_w-1:0]  w_winner;
    logic [N_REQ-1:0]   w_gnt_onehot;

    // Round-robin pick: lowest requester above the last grant, else wrap to
    // the lowest requester overall. Descending scan leaves the lowest match.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (bus.req[c_id_w'(j)]) begin
                w_lo_id = c_id_w'(j);
                if (c_id_w'(j) > last_q) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = c_id_w'(j);
                end
            end
        end
        w_winner     = w_hi_found ? w_hi_id : w_lo_id;
        w_gnt_onehot = c_one << gnt_id_q;
    end

    // Next-state and registered-output logic for the IDLE/GRANT/GAP sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ce_d        = ce_q;
        gnt_id_d    = gnt_id_q;
        last_d      = last_q;
        gnt_valid_d = gnt_valid_q;
        done_d      = '0;

        case (state_q)
            S_IDLE: begin
                ce_d        = '0;
                gnt_valid_d = 1'b0;
                if (|bus.req) begin
                    state_d     = S_GRANT;
                    gnt_id_d    = w_winner;
                    last_d      = w_winner;
                    ce_d        = c_one << w_winner;
                    gnt_valid_d = 1'b1;
                    cnt_d       = c_burst_init;
                end
            end

            S_GRANT: begin
                if (!bus.req[gnt_id_q]) begin
                    // Abort wins over hold and over completion; no done pulse.
                    ce_d        = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = c_has_gap ? S_GAP : S_IDLE;
                    cnt_d       = c_gap_init;
                end else if ((|ce_q) && (cnt_q == '0)) begin
                    // Final active cycle just elapsed.
                    ce_d             = '0;
                    gnt_valid_d      = 1'b0;
                    done_d[gnt_id_q] = 1'b1;
                    state_d          = c_has_gap ? S_GAP : S_IDLE;
                    cnt_d            = c_gap_init;
                end else begin
                    // Only cycles in which the enable was really high consume
                    // burst credit, so held cycles are not lost.
                    if (|ce_q) begin
                        cnt_d = cnt_q - c_cnt_one;
                    end
                    ce_d = bus.hold ? '0 : w_gnt_onehot;
                end
            end

            S_GAP: begin
                ce_d        = '0;
                gnt_valid_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end

            default: begin
                state_d     = S_IDLE;
                ce_d        = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ce_q        <= '0;
            gnt_id_q    <= '0;
            last_q      <= c_last_init;
            gnt_valid_q <= 1'b0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            gnt_id_q    <= gnt_id_d;
            last_q      <= last_d;
            gnt_valid_q <= gnt_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.ce        = ce_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_en_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_en_scheduler
// Description : Directed self-checking bench for clk_en_scheduler. Instance A
//               uses BURST_LEN=8/GAP_LEN=2, instance B BURST_LEN=1/GAP_LEN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_en_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    clk_en_scheduler_if #(.N_REQ(4)) bus_a ();
    clk_en_scheduler_if #(.N_REQ(4)) bus_b ();

    clk_en_scheduler #(.N_REQ(4), .BURST_LEN(8), .GAP_LEN(2), .CNT_W(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    clk_en_scheduler #(.N_REQ(4), .BURST_LEN(1), .GAP_LEN(0), .CNT_W(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let instance A drain back to IDLE within a bounded number of cycles.
    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        while (bus_a.busy && n < 40) begin
            step();
            n++;
        end
        total++;
        if (bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: busy=%b after %0d cycles, want 0", name, bus_a.busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus_a.req  = '0;
        bus_a.hold = 1'b0;
        bus_b.req  = '0;
        bus_b.hold = 1'b0;
        step();
        step();
        total++; if (bus_a.ce !== 4'b0000) begin bad++; $display("FAIL rst_ce: got %b want 0000", bus_a.ce); end
        total++; if (bus_a.gnt_id !== 2'd0) begin bad++; $display("FAIL rst_gnt_id: got %0d want 0", bus_a.gnt_id); end
        total++; if (bus_a.gnt_valid !== 1'b0) begin bad++; $display("FAIL rst_gnt_valid: got %b want 0", bus_a.gnt_valid); end
        total++; if (bus_a.done !== 4'b0000) begin bad++; $display("FAIL rst_done: got %b want 0000", bus_a.done); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus_a.busy); end
        total++; if (bus_b.ce !== 4'b0000 || bus_b.busy !== 1'b0) begin bad++; $display("FAIL rst_b: ce=%b busy=%b want 0000/0", bus_b.ce, bus_b.busy); end
        rst_n = 1'b1;
        step();
        total++; if (bus_a.busy !== 1'b0 || bus_a.ce !== 4'b0000) begin bad++; $display("FAIL idle_no_req: busy=%b ce=%b want 0/0000", bus_a.busy, bus_a.ce); end
    endtask

    // Single requester: 8 enable cycles, done on the following cycle, busy
    // drops on the third cycle after the last enable.
    task automatic test_single();
        bus_a.req = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            step();
            total++; if (bus_a.ce !== 4'b0001) begin bad++; $display("FAIL single_ce[%0d]: got %b want 0001", n, bus_a.ce); end
            total++; if (bus_a.gnt_valid !== 1'b1 || bus_a.busy !== 1'b1) begin bad++; $display("FAIL single_valid[%0d]: gnt_valid=%b busy=%b want 1/1", n, bus_a.gnt_valid, bus_a.busy); end
        end
        step();
        total++; if (bus_a.ce !== 4'b0000) begin bad++; $display("FAIL single_ce_end: got %b want 0000", bus_a.ce); end
        total++; if (bus_a.done !== 4'b0001) begin bad++; $display("FAIL single_done: got %b want 0001", bus_a.done); end
        total++; if (bus_a.busy !== 1'b1 || bus_a.gnt_valid !== 1'b0) begin bad++; $display("FAIL single_gap1: busy=%b gnt_valid=%b want 1/0", bus_a.busy, bus_a.gnt_valid); end
        bus_a.req = 4'b0000;
        step();
        total++; if (bus_a.done !== 4'b0000 || bus_a.busy !== 1'b1) begin bad++; $display("FAIL single_gap2: done=%b busy=%b want 0000/1", bus_a.done, bus_a.busy); end
        step();
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b want 0", bus_a.busy); end
        total++; if (bus_a.gnt_id !== 2'd0) begin bad++; $display("FAIL single_gnt_keep: gnt_id=%0d want 0", bus_a.gnt_id); end
    endtask

    // All requests high from reset: 8 enable cycles per grant, period 11.
    task automatic test_round_robin();
        logic [3:0] exp_ce;
        logic [3:0] exp_done;
        int p;
        int g;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus_a.req = 4'b1111;
        for (int t = 1; t <= 60; t++) begin
            step();
            p = (t - 1) % 11;
            g = ((t - 1) / 11) % 4;
            exp_ce   = (p < 8)  ? (4'b0001 << g) : 4'b0000;
            exp_done = (p == 8) ? (4'b0001 << ((g + 0) % 4)) : 4'b0000;
            total++; if (bus_a.ce !== exp_ce) begin bad++; $display("FAIL rr_ce[t=%0d]: got %b want %b", t, bus_a.ce, exp_ce); end
            total++; if (bus_a.done !== exp_done) begin bad++; $display("FAIL rr_done[t=%0d]: got %b want %b", t, bus_a.done, exp_done); end
            if (p < 8) begin
                total++; if (bus_a.gnt_id !== 2'(g)) begin bad++; $display("FAIL rr_gnt_id[t=%0d]: got %0d want %0d", t, bus_a.gnt_id, g); end
            end
        end
        bus_a.req = 4'b0000;
        wait_idle_a("rr");
    endtask

    // Slice 2 held for 5 cycles after its third enable cycle.
    task automatic test_hold();
        logic [3:0] exp_ce;
        logic [3:0] exp_done;
        int ce_cnt;
        int done_cnt;
        ce_cnt   = 0;
        done_cnt = 0;
        bus_a.req = 4'b0100;
        for (int n = 1; n <= 16; n++) begin
            step();
            exp_ce   = (n <= 3 || (n >= 9 && n <= 13)) ? 4'b0100 : 4'b0000;
            exp_done = (n == 14) ? 4'b0100 : 4'b0000;
            total++; if (bus_a.ce !== exp_ce) begin bad++; $display("FAIL hold_ce[%0d]: got %b want %b", n, bus_a.ce, exp_ce); end
            total++; if (bus_a.done !== exp_done) begin bad++; $display("FAIL hold_done[%0d]: got %b want %b", n, bus_a.done, exp_done); end
            if (n <= 13) begin
                total++; if (bus_a.gnt_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", n, bus_a.gnt_valid); end
            end
            if (bus_a.ce == 4'b0100) ce_cnt++;
            if (bus_a.done == 4'b0100) done_cnt++;
            if (n == 3) bus_a.hold = 1'b1;
            if (n == 8) bus_a.hold = 1'b0;
            if (n == 16) bus_a.req = 4'b0000;
        end
        total++; if (ce_cnt != 8) begin bad++; $display("FAIL hold_ce_total: got %0d want 8", ce_cnt); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL hold_done_total: got %0d want 1", done_cnt); end
        wait_idle_a("hold");
    endtask

    // Slice 1 drops its request after 3 enable cycles; slice 2 waits.
    task automatic test_abort();
        bus_a.req = 4'b0010;
        for (int n = 1; n <= 3; n++) begin
            step();
            total++; if (bus_a.ce !== 4'b0010) begin bad++; $display("FAIL abort_ce[%0d]: got %b want 0010", n, bus_a.ce); end
        end
        bus_a.req = 4'b0100;
        step();
        total++; if (bus_a.ce !== 4'b0000 || bus_a.gnt_valid !== 1'b0) begin bad++; $display("FAIL abort_stop: ce=%b gnt_valid=%b want 0000/0", bus_a.ce, bus_a.gnt_valid); end
        total++; if (bus_a.done !== 4'b0000 || bus_a.busy !== 1'b1) begin bad++; $display("FAIL abort_gap1: done=%b busy=%b want 0000/1", bus_a.done, bus_a.busy); end
        step();
        total++; if (bus_a.done !== 4'b0000 || bus_a.busy !== 1'b1 || bus_a.ce !== 4'b0000) begin bad++; $display("FAIL abort_gap2: done=%b busy=%b ce=%b want 0000/1/0000", bus_a.done, bus_a.busy, bus_a.ce); end
        step();
        total++; if (bus_a.busy !== 1'b0 || bus_a.ce !== 4'b0000) begin bad++; $display("FAIL abort_idle: busy=%b ce=%b want 0/0000", bus_a.busy, bus_a.ce); end
        step();
        total++; if (bus_a.ce !== 4'b0100 || bus_a.gnt_id !== 2'd2) begin bad++; $display("FAIL abort_next: ce=%b gnt_id=%0d want 0100/2", bus_a.ce, bus_a.gnt_id); end
        bus_a.req = 4'b0000;
        wait_idle_a("abort");
    endtask

    // Reset pulled mid-burst between clock edges.
    task automatic test_async_reset();
        bus_a.req = 4'b1111;
        step();
        total++; if (bus_a.ce !== 4'b1000) begin bad++; $display("FAIL areset_pre: ce=%b want 1000", bus_a.ce); end
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus_a.ce !== 4'b0000 || bus_a.gnt_valid !== 1'b0) begin bad++; $display("FAIL areset_ce: ce=%b gnt_valid=%b want 0000/0", bus_a.ce, bus_a.gnt_valid); end
        total++; if (bus_a.busy !== 1'b0 || bus_a.done !== 4'b0000 || bus_a.gnt_id !== 2'd0) begin bad++; $display("FAIL areset_status: busy=%b done=%b gnt_id=%0d want 0/0000/0", bus_a.busy, bus_a.done, bus_a.gnt_id); end
        #1;
        rst_n = 1'b1;
        step();
        total++; if (bus_a.ce !== 4'b0001 || bus_a.gnt_id !== 2'd0) begin bad++; $display("FAIL areset_first: ce=%b gnt_id=%0d want 0001/0", bus_a.ce, bus_a.gnt_id); end
        bus_a.req = 4'b0000;
        wait_idle_a("areset");
    endtask

    // BURST_LEN=1, GAP_LEN=0 instance: 01, 0, 10, 0, ...
    task automatic test_back_to_back();
        logic [3:0] exp_ce;
        logic [3:0] exp_done;
        logic       exp_busy;
        int k;
        bus_b.req = 4'b0011;
        for (int n = 1; n <= 8; n++) begin
            step();
            k = (n - 1) / 2;
            if (n % 2 == 1) begin
                exp_ce   = (k % 2 == 0) ? 4'b0001 : 4'b0010;
                exp_done = 4'b0000;
                exp_busy = 1'b1;
            end else begin
                exp_ce   = 4'b0000;
                exp_done = (k % 2 == 0) ? 4'b0001 : 4'b0010;
                exp_busy = 1'b0;
            end
            total++; if (bus_b.ce !== exp_ce) begin bad++; $display("FAIL b2b_ce[%0d]: got %b want %b", n, bus_b.ce, exp_ce); end
            total++; if (bus_b.done !== exp_done) begin bad++; $display("FAIL b2b_done[%0d]: got %b want %b", n, bus_b.done, exp_done); end
            total++; if (bus_b.busy !== exp_busy) begin bad++; $display("FAIL b2b_busy[%0d]: got %b want %b", n, bus_b.busy, exp_busy); end
        end
        bus_b.req = 4'b0000;
        step();
        step();
        total++; if (bus_b.busy !== 1'b0 || bus_b.ce !== 4'b0000) begin bad++; $display("FAIL b2b_end: busy=%b ce=%b want 0/0000", bus_b.busy, bus_b.ce); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
